mp_subtractor_seq: RTL

- Iterative multi-precision subtractor for the modular-arithmetic datapath: computes a − b on 1028-bit operands, one limb per clock, with a start/done handshake.
- Companion to the carry-select adder. Used for the Montgomery final conditional subtraction and for comparisons, via the sign/borrow output.
- Trades latency (NLIMB cycles) for area: a single LIMB-wide subtract-with-borrow slice.

---
 rtl/mp_subtractor_seq_pkg.sv | 19 +
 rtl/mp_subtractor_seq_if.sv | 23 ++
 rtl/mp_subtractor_seq_sub_limb.sv | 15 +
 rtl/mp_subtractor_seq.sv | 99 +++++++++
 4 files changed

// File: rtl/mp_subtractor_seq_pkg.sv
// Shared constants and FSM encoding for the iterative multi-precision subtractor.
package mp_subtractor_seq_pkg;

    localparam int WIDTH    = 1028;
    localparam int LIMB     = 128;
    localparam int NLIMB    = (WIDTH + LIMB - 1) / LIMB;
    localparam int PAD_W    = NLIMB * LIMB;
    localparam int PAD_BITS = PAD_W - WIDTH;
    localparam int CNT_W    = $clog2(NLIMB);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NLIMB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mp_subtractor_seq_if.sv
// Start/done request and result bus of the subtractor; master issues, slave computes.
interface mp_subtractor_seq_if;
    import mp_subtractor_seq_pkg::*;

    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH:0]   result;
    logic             borrow;
    logic             busy;
    logic             done;

    modport master (
        output start, in_a, in_b,
        input  result, borrow, busy, done
    );

    modport slave (
        input  start, in_a, in_b,
        output result, borrow, busy, done
    );

endinterface

// File: rtl/mp_subtractor_seq_sub_limb.sv
// One limb of subtract-with-borrow: d = a - b - bin, bout set when the limb underflows.
module mp_subtractor_seq_sub_limb
    import mp_subtractor_seq_pkg::*;
(
    input  logic [LIMB-1:0] a_i,
    input  logic [LIMB-1:0] b_i,
    input  logic            bin_i,
    output logic [LIMB-1:0] d_o,
    output logic            bout_o
);

    // The extra top bit of the widened difference is the borrow out of the limb.
    assign {bout_o, d_o} = {1'b0, a_i} - {1'b0, b_i} - {{LIMB{1'b0}}, bin_i};

endmodule

// File: rtl/mp_subtractor_seq.sv
// Iterative WIDTH-bit subtractor: one LIMB slice per clock, start/done handshake, sign on borrow.
module mp_subtractor_seq
    import mp_subtractor_seq_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    mp_subtractor_seq_if.slave  bus
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PAD_W-1:0] a_q;
    logic [PAD_W-1:0] b_q;
    logic [PAD_W-1:0] diff_q;
    logic             bor_q;
    logic [WIDTH:0]   result_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

    logic [LIMB-1:0]  limb_diff_s;
    logic             limb_bout_s;
    logic [PAD_W-1:0] a_d;
    logic [PAD_W-1:0] b_d;
    logic [PAD_W-1:0] diff_d;

    mp_subtractor_seq_sub_limb u_sub_limb (
        .a_i    (a_q[LIMB-1:0]),
        .b_i    (b_q[LIMB-1:0]),
        .bin_i  (bor_q),
        .d_o    (limb_diff_s),
        .bout_o (limb_bout_s)
    );

    // Next values of the shifting operand and difference registers during RUN.
    always_comb begin
        a_d    = {{LIMB{1'b0}}, a_q[PAD_W-1:LIMB]};
        b_d    = {{LIMB{1'b0}}, b_q[PAD_W-1:LIMB]};
        diff_d = {limb_diff_s, diff_q[PAD_W-1:LIMB]};
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bor_q    <= 1'b0;
            result_q <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_q     <= {{PAD_BITS{1'b0}}, bus.in_a};
                        b_q     <= {{PAD_BITS{1'b0}}, bus.in_b};
                        bor_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q    <= a_d;
                    b_q    <= b_d;
                    diff_q <= diff_d;
                    bor_q  <= limb_bout_s;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // The final limb lands on this edge, so publish from diff_d, not diff_q.
                    if (cnt_q == CNT_LAST) begin
                        result_q <= diff_d[WIDTH:0];
                        borrow_q <= diff_d[WIDTH];
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.borrow = borrow_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule
